// File: rtl/xalu_pkg.sv
// Shared types and helpers for the nibble-serial ALU sequencer.
package xalu_pkg;

   typedef enum logic [2:0] {
      OP_ADD   = 3'd0,
      OP_AND   = 3'd1,
      OP_OR    = 3'd2,
      OP_XOR   = 3'd3,
      OP_PASSA = 3'd4,
      OP_PASSB = 3'd5,
      OP_SHR   = 3'd6,
      OP_SHL   = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int NIBBLES = 4;

   // Right shifts walk from the top nibble down so the carry flows toward bit 0.
   function automatic logic [1:0] nib_index(input op_t op, input logic [1:0] idx);
      return (op == OP_SHR) ? (2'd3 - idx) : idx;
   endfunction

   function automatic logic op_has_carry(input op_t op);
      return (op == OP_ADD) || (op == OP_SHL) || (op == OP_SHR);
   endfunction

endpackage

// File: rtl/xalu_nib_sel.sv
// Nibble operand select, result nibble insert and carry-in routing for the slice.
module xalu_nib_sel
   import xalu_pkg::*;
(
   input  logic        run,
   input  op_t         op,
   input  logic        com,
   input  logic        cin,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] result,
   input  logic [1:0]  idx,
   input  logic        carry,
   input  logic [3:0]  s_d,
   input  logic        s_co_left,
   input  logic        s_co_right,
   output logic [3:0]  s_a,
   output logic [3:0]  s_b,
   output logic [2:0]  s_f,
   output logic        s_com,
   output logic        s_ci_left,
   output logic        s_ci_right,
   output logic [15:0] result_next,
   output logic        carry_next
);

   logic [1:0] n;
   logic       carry_in;

   assign n        = nib_index(op, idx);
   assign carry_in = (idx == 2'd0) ? cin : carry;

   always_comb begin
      s_a        = 4'd0;
      s_b        = 4'd0;
      s_f        = 3'd0;
      s_com      = 1'b0;
      s_ci_left  = 1'b0;
      s_ci_right = 1'b0;
      if (run) begin
         s_a   = a[{n, 2'b00} +: 4];
         s_b   = b[{n, 2'b00} +: 4];
         s_f   = op;
         s_com = com;
         case (op)
            OP_ADD, OP_SHL: s_ci_right = carry_in;
            OP_SHR:         s_ci_left  = carry_in;
            default:        ;
         endcase
      end
   end

   assign carry_next = (op == OP_SHR) ? s_co_right : s_co_left;

   genvar gi;
   generate
      for (gi = 0; gi < NIBBLES; gi++) begin : g_ins
         assign result_next[gi*4 +: 4] = (n == 2'(gi)) ? s_d : result[gi*4 +: 4];
      end
   endgenerate

endmodule

// File: rtl/xalu_seq.sv
// 16-bit ALU sequencer driving an external 4-bit slice over four nibble cycles.
// Optional signed-overflow flag for ADD enabled by defining XALU_SEQ_OVF_EN.
module xalu_seq
   import xalu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic        com,
   input  logic        cin,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        cout,
   output logic        zero,
   output logic        neg_zero,
   output logic        equ,
   output logic        ovf,
   output logic [3:0]  s_a,
   output logic [3:0]  s_b,
   output logic [2:0]  s_f,
   output logic        s_com,
   output logic        s_ci_left,
   output logic        s_ci_right,
   input  logic [3:0]  s_d,
   input  logic        s_co_left,
   input  logic        s_co_right,
   input  logic        s_equ
);

   state_t      state_reg;
   op_t         op_reg;
   logic        com_reg, cin_reg, carry_reg, cout_reg, equ_reg;
   logic [1:0]  idx_reg;
   logic [15:0] a_reg, b_reg, result_reg, result_next;
   logic        carry_next, run, last;

   assign run  = (state_reg == ST_RUN);
   assign last = run && (idx_reg == 2'(NIBBLES - 1));

   xalu_nib_sel u_nib_sel (
      .run         (run),
      .op          (op_reg),
      .com         (com_reg),
      .cin         (cin_reg),
      .a           (a_reg),
      .b           (b_reg),
      .result      (result_reg),
      .idx         (idx_reg),
      .carry       (carry_reg),
      .s_d         (s_d),
      .s_co_left   (s_co_left),
      .s_co_right  (s_co_right),
      .s_a         (s_a),
      .s_b         (s_b),
      .s_f         (s_f),
      .s_com       (s_com),
      .s_ci_left   (s_ci_left),
      .s_ci_right  (s_ci_right),
      .result_next (result_next),
      .carry_next  (carry_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         idx_reg    <= 2'd0;
         carry_reg  <= 1'b0;
         result_reg <= 16'd0;
         cout_reg   <= 1'b0;
         equ_reg    <= 1'b0;
         op_reg     <= OP_ADD;
         com_reg    <= 1'b0;
         cin_reg    <= 1'b0;
         a_reg      <= 16'd0;
         b_reg      <= 16'd0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  op_reg    <= op_t'(op);
                  com_reg   <= com;
                  cin_reg   <= cin;
                  a_reg     <= a;
                  b_reg     <= b;
                  idx_reg   <= 2'd0;
                  carry_reg <= 1'b0;
                  equ_reg   <= 1'b1;
                  state_reg <= ST_RUN;
               end
            end
            ST_RUN: begin
               result_reg <= result_next;
               carry_reg  <= carry_next;
               equ_reg    <= equ_reg & s_equ;
               idx_reg    <= idx_reg + 2'd1;
               if (last) begin
                  state_reg <= ST_DONE;
                  cout_reg  <= op_has_carry(op_reg) ? carry_next : 1'b0;
               end
            end
            ST_DONE: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

`ifdef XALU_SEQ_OVF_EN
   logic ovf_reg;

   // Uses result_next so the flag lands together with the final nibble.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_reg <= 1'b0;
      end else if (last) begin
         ovf_reg <= (op_reg == OP_ADD) && !com_reg && (a_reg[15] == b_reg[15])
                    && (result_next[15] != a_reg[15]);
      end
   end
   assign ovf = ovf_reg;
`else
   assign ovf = 1'b0;
`endif

   assign busy     = (state_reg != ST_IDLE);
   assign done     = (state_reg == ST_DONE);
   assign result   = result_reg;
   assign cout     = cout_reg;
   assign equ      = equ_reg;
   assign zero     = (result_reg == 16'h0000);
   assign neg_zero = (result_reg == 16'hFFFF);

endmodule
